// File: rtl/tone_generator.sv
// rtl/tone_generator.sv - square-wave tone stage: plays a latched note, then a fixed silent gap
module tone_generator #(
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        note_val,
  output logic        note_rdy,
  input  logic [15:0] half_period,
  input  logic [15:0] duration,
  output logic        spk,
  output logic        busy,
  output logic        note_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);

  state_t      state;
  logic [15:0] hp_q;
  logic [15:0] dur_cnt;
  logic [15:0] phase_cnt;
  logic [15:0] gap_cnt;

  assign note_rdy = (state == IDLE) && en;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hp_q      <= '0;
      dur_cnt   <= '0;
      phase_cnt <= '0;
      gap_cnt   <= '0;
      spk       <= 1'b0;
      note_done <= 1'b0;
    end else begin
      // note_done is a single-cycle pulse even while paused
      note_done <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            spk <= 1'b0;
            if (note_val) begin
              hp_q      <= half_period;
              phase_cnt <= '0;
              if (duration != 16'd0) begin
                dur_cnt <= duration;
                state   <= PLAY;
              end else begin
                gap_cnt <= GAP_LOAD;
                state   <= GAP;
              end
            end
          end
          PLAY: begin
            if (dur_cnt == 16'd1) begin
              spk       <= 1'b0;
              phase_cnt <= '0;
              gap_cnt   <= GAP_LOAD;
              state     <= GAP;
            end else begin
              dur_cnt <= dur_cnt - 16'd1;
              if (hp_q == 16'd0) begin
                spk <= 1'b0;
              end else if (phase_cnt == hp_q - 16'd1) begin
                phase_cnt <= '0;
                spk       <= ~spk;
              end else begin
                phase_cnt <= phase_cnt + 16'd1;
              end
            end
          end
          GAP: begin
            spk <= 1'b0;
            if (gap_cnt == 16'd1) begin
              note_done <= 1'b1;
              state     <= IDLE;
            end else begin
              gap_cnt <= gap_cnt - 16'd1;
            end
          end
          default: begin
            spk   <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
